bp_update_scheduler: RTL and testbench

- Sits between the ID-stage branch resolution logic and the branch predictor's BTB update port.
- Accepts resolved-branch records through a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO at one BTB write per cycle, detects mispredictions and issues a registered fetch redirect.
- Runs a BTB invalidate sweep on request, arbitrating the single update port between the drain and the sweep.

---
 rtl/bp_update_scheduler.sv | 172 +++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_scheduler.sv
// Buffers resolved-branch records, drains them into the BTB update port, flags mispredicts
// and runs BTB invalidate sweeps. Optional statistics counters: define BP_SCHED_STATS_EN.
module bp_update_scheduler #(
    parameter int QDEPTH = 4,
    parameter int IDX_W  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic [1:0]  res_state,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    input  logic        flush_req,
    output logic        upd_en,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_taken,
    output logic [1:0]  upd_state,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        sweep_busy
`ifdef BP_SCHED_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispredict,
    output logic [31:0] stat_stall
`endif
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [1:0]  state;
    } upd_rec_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Handshake: a record transfers on a rising edge where res_valid & res_ready;
    // res_ready depends only on registered FIFO occupancy, never on res_valid.

    upd_rec_t          mem [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    state_t            state, state_nxt;
    logic [IDX_W-1:0]  sweep_cnt, sweep_cnt_nxt;
    logic              push, pop, flush_idle, is_mispred;
    upd_rec_t          head, in_rec;

    assign res_ready  = (count != CNT_W'(QDEPTH));
    assign push       = res_valid & res_ready;
    assign flush_idle = (state == ST_IDLE) & flush_req;
    assign sweep_busy = (state == ST_SWEEP);
    assign head       = mem[rd_ptr];
    assign in_rec     = '{pc: res_pc, target: res_target, taken: res_taken, state: res_state};

    assign is_mispred = (res_taken != res_pred_taken) |
                        (res_taken & res_pred_taken & (res_target != res_pred_target));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_cnt_nxt;
        end
    end

    // A flush in IDLE wins over draining so queued entries never reach the BTB.
    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        pop           = 1'b0;
        upd_en        = 1'b0;
        upd_pc        = '0;
        upd_target    = '0;
        upd_taken     = 1'b0;
        upd_state     = '0;
        case (state)
            ST_IDLE: begin
                if (flush_req) begin
                    state_nxt     = ST_SWEEP;
                    sweep_cnt_nxt = '0;
                end else if (count != '0) begin
                    pop        = 1'b1;
                    upd_en     = 1'b1;
                    upd_pc     = head.pc;
                    upd_target = head.target;
                    upd_taken  = head.taken;
                    upd_state  = head.state;
                end
            end
            ST_SWEEP: begin
                upd_en        = 1'b1;
                upd_pc        = 32'(sweep_cnt);
                sweep_cnt_nxt = sweep_cnt + 1'b1;
                if (sweep_cnt == '1) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_idle) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= push & is_mispred;
            if (push & is_mispred) begin
                redirect_pc <= res_taken ? res_target : res_pc + 32'd4;
            end
        end
    end

`ifdef BP_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved   <= '0;
            stat_mispredict <= '0;
            stat_stall      <= '0;
        end else begin
            if (push && stat_resolved != 32'hFFFF_FFFF) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (mispredict && stat_mispredict != 32'hFFFF_FFFF) begin
                stat_mispredict <= stat_mispredict + 32'd1;
            end
            if (res_valid && !res_ready && stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Randomized bench for bp_update_scheduler against a queue-based reference model.
module tb_bp_update_scheduler;

    localparam int QDEPTH = 4;
    localparam int IDX_W  = 5;
    localparam int NSWEEP = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [31:0] res_pc = '0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic [1:0]  res_state = '0;
    logic        res_pred_taken = 1'b0;
    logic [31:0] res_pred_target = '0;
    logic        flush_req = 1'b0;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [1:0]  upd_state;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        sweep_busy;
`ifdef BP_SCHED_STATS_EN
    logic [31:0] stat_resolved, stat_mispredict, stat_stall;
`endif

    bp_update_scheduler #(.QDEPTH(QDEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
        .res_state(res_state), .res_pred_taken(res_pred_taken),
        .res_pred_target(res_pred_target), .flush_req(flush_req),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_state(upd_state),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .sweep_busy(sweep_busy)
`ifdef BP_SCHED_STATS_EN
        , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: queue of {pc, target, taken, state}, sweep progress, redirect regs.
    logic [66:0]  exp_q[$];
    bit           sweeping;
    int           sweep_idx;
    logic         exp_mp;
    logic [31:0]  exp_rpc;
    logic [102:0] exp_vec;
    logic [102:0] act_vec;
    int           vectors = 0;
    int           miscompares = 0;

    assign act_vec = {upd_en, upd_pc, upd_target, upd_taken, upd_state,
                      mispredict, redirect_pc, sweep_busy, res_ready};

    task automatic model_reset();
        exp_q.delete();
        sweeping  = 1'b0;
        sweep_idx = 0;
        exp_mp    = 1'b0;
        exp_rpc   = '0;
    endtask

    task automatic model_expect();
        logic        e_en, e_tk;
        logic [31:0] e_pc, e_tg;
        logic [1:0]  e_st;
        e_en = 1'b0; e_pc = '0; e_tg = '0; e_tk = 1'b0; e_st = '0;
        if (sweeping) begin
            e_en = 1'b1;
            e_pc = 32'(sweep_idx);
        end else if (exp_q.size() != 0 && !flush_req) begin
            e_en = 1'b1;
            {e_pc, e_tg, e_tk, e_st} = exp_q[0];
        end
        exp_vec = {e_en, e_pc, e_tg, e_tk, e_st, exp_mp, exp_rpc, sweeping,
                   (exp_q.size() < QDEPTH)};
    endtask

    task automatic model_commit();
        bit acc, mis;
        acc = res_valid && (exp_q.size() < QDEPTH);
        mis = (res_taken != res_pred_taken) || (res_taken && res_target != res_pred_target);
        exp_mp = acc && mis;
        if (acc && mis) exp_rpc = res_taken ? res_target : res_pc + 32'd4;
        if (sweeping) begin
            if (acc) exp_q.push_back({res_pc, res_target, res_taken, res_state});
            sweep_idx++;
            if (sweep_idx == NSWEEP) sweeping = 1'b0;
        end else if (flush_req) begin
            exp_q.delete();
            sweeping  = 1'b1;
            sweep_idx = 0;
        end else begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc) exp_q.push_back({res_pc, res_target, res_taken, res_state});
        end
    endtask

    task automatic set_in(input bit v, input logic [31:0] pc, input bit tk,
                          input logic [31:0] tg, input logic [1:0] st, input bit ptk,
                          input logic [31:0] ptg, input bit fl);
        res_valid = v; res_pc = pc; res_taken = tk; res_target = tg;
        res_state = st; res_pred_taken = ptk; res_pred_target = ptg; flush_req = fl;
    endtask

    task automatic idle_in();
        set_in(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, '0, 1'b0);
    endtask

    // Keeps the offered record stable while it is being back-pressured.
    task automatic rand_in(input bit v, input bit fl);
        logic [31:0] pc, tg;
        bit          tk;
        if (res_valid && exp_q.size() >= QDEPTH) begin
            flush_req = fl;
            return;
        end
        pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00} >> 2 << 2;
        tg = $urandom() & 32'hFFFF_FFFC;
        tk = 1'($urandom_range(0, 1));
        set_in(v, pc, tk, tg, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0) ? tk : !tk,
               ($urandom_range(0, 2) == 0) ? ($urandom() & 32'hFFFF_FFFC) : tg, fl);
    endtask

    task automatic sample();
        @(negedge clk);
        model_expect();
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        idle_in();
        sample();
        vectors++;
        if (act_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL reset_state act=%h exp=%h", act_vec, exp_vec);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: set_in(1'b1, 32'h100, 1'b1, 32'h200, 2'd3, 1'b1, 32'h200, 1'b0);
                2: set_in(1'b1, 32'h40, 1'b0, 32'h999, 2'd1, 1'b1, 32'h999, 1'b0);
                3: set_in(1'b1, 32'h80, 1'b1, 32'h300, 2'd2, 1'b1, 32'h280, 1'b0);
                5: set_in(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 2'd0, 1'b1, 32'h0, 1'b0);
                default: idle_in();
            endcase
            sample();
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL directed step=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_sweep_backpressure();
        for (int i = 0; i < NSWEEP + 12; i++) begin
            if (i == 0) set_in(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, '0, 1'b1);
            else if (i <= NSWEEP) rand_in(1'b1, i == 10);
            else idle_in();
            sample();
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL sweep_backpressure cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_flush_queued();
        int busy_cnt = 0;
        for (int i = 0; i < 2 * NSWEEP + 8; i++) begin
            if (i == 0 || i == NSWEEP + 1) set_in(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, '0, 1'b1);
            else if (i == 3 || i == 4 || i == NSWEEP + 6) rand_in(1'b1, 1'b0);
            else if (i == NSWEEP + 12) rand_in(1'b0, 1'b1);
            else idle_in();
            sample();
            if (i > NSWEEP) busy_cnt += int'(sweep_busy);
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL flush_queued cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
            tick();
        end
        vectors++;
        if (busy_cnt !== NSWEEP) begin
            miscompares++;
            $display("FAIL sweep_length act=%0d exp=%0d", busy_cnt, NSWEEP);
        end
    endtask

    task automatic test_reset_mid_sweep();
        set_in(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 12 && !(sweeping && sweep_idx == 10); i++) begin
            if (i == 0) ;
            else if (i == 9) set_in(1'b1, 32'h40, 1'b0, '0, 2'd1, 1'b1, '0, 1'b0);
            else idle_in();
            sample();
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL pre_reset cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
            tick();
        end
        idle_in();
        sample();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({upd_en, sweep_busy, mispredict} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset act=%b exp=000", {upd_en, sweep_busy, mispredict});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_in(1'($urandom_range(0, 2) != 0), $urandom_range(0, 40) == 0);
            sample();
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
            tick();
        end
        idle_in();
        for (int i = 0; i < NSWEEP + QDEPTH + 2; i++) begin
            sample();
            vectors++;
            if (act_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random_drain cyc=%0d act=%h exp=%h", i, act_vec, exp_vec);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_sweep_backpressure();
        test_flush_queued();
        test_reset_mid_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
